mem_dump_streamer: RTL

//  Read-out engine for the MIPS32 pipeline's data memory: on processor halt, walks Mem[BASE..BASE+COUNT-1]
//  and streams each word out on a valid/ready interface, in address order.

---
 rtl/mem_dump_pkg.sv | 15 +
 rtl/mem_dump_streamer_if.sv | 28 ++
 rtl/mem_dump_fifo2.sv | 60 ++++++
 rtl/mem_dump_streamer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and default widths for the data-memory dump streamer.
package mem_dump_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int CNT_W_DEF  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_dump_streamer_if.sv
// Memory read port plus outgoing word stream of the dump streamer.
interface mem_dump_streamer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );
endinterface

// File: rtl/mem_dump_fifo2.sv
// Two-entry FIFO holding words returned from memory until the consumer takes them.
module mem_dump_fifo2 #(
  parameter int W = 43
) (
  input  logic         clk1,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  // next pointers, occupancy and storage contents
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // pointer and occupancy registers, flushed on reset
  always_ff @(posedge clk1) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage needs no reset: it is only visible through a non-empty head
  always_ff @(posedge clk1) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign cnt   = cnt_q;

endmodule

// File: rtl/mem_dump_streamer.sv
// Walks data memory after processor halt, streams words out in address order
// and tracks whether the sequence is non-decreasing (signed).
//
//  state | meaning
//  IDLE  | waiting for halted rising edge
//  READ  | issuing reads, limited to two words held or in flight
//  DRAIN | all reads issued, waiting for the last beat to be accepted
//  DONE  | result valid; a new halted rising edge restarts
module mem_dump_streamer
  import mem_dump_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk1,
  input  logic                 reset,
  input  logic                 halted,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     count,
  mem_dump_streamer_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 sorted_ok,
  output logic [CNT_W-1:0]     inversions
);

  localparam int FW = DATA_W + ADDR_W + 1;

  state_e             state_q, state_d;
  logic               halted_q, halted_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
  logic               pend_last_q, pend_last_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic               have_prev_q, have_prev_d;
  logic               sorted_q, sorted_d;
  logic [CNT_W-1:0]   inv_q, inv_d;

  logic               start, launch, rd_en, pop, last_pop;
  logic [1:0]         fifo_cnt;
  logic               fifo_full, fifo_empty;
  logic [FW-1:0]      fifo_din, fifo_dout;
  logic [DATA_W-1:0]  head_data;
  logic [ADDR_W-1:0]  head_addr;
  logic               head_last;
  logic [2:0]         credit_used;

  assign halted_d = halted;
  assign start    = halted & ~halted_q;
  assign launch   = start & ((state_q == IDLE) | (state_q == DONE));
  assign pop      = ~fifo_empty & bus.out_ready;
  assign {head_last, head_addr, head_data} = fifo_dout;
  assign last_pop = pop & head_last;
  assign fifo_din = {pend_last_q, pend_addr_q, bus.mem_rd_data};

  // the word leaving this cycle frees its slot, which keeps one beat per cycle
  assign credit_used = {1'b0, fifo_cnt} + {2'b00, pend_q} - {2'b00, pop};
  assign rd_en       = (state_q == READ) && (credit_used < 3'd2) && !(fifo_full && !pop);

  mem_dump_fifo2 #(.W(FW)) u_fifo (
    .clk1  (clk1),
    .reset (reset),
    .push  (pend_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  // FSM state register
  always_ff @(posedge clk1) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; halted edges outside IDLE/DONE are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (count == '0) ? DONE : READ;
      READ:       if (rd_en && (remain_q == CNT_W'(1))) state_d = DRAIN;
      DRAIN:      if (last_pop) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM and stream outputs; the head is masked to zero while nothing is held
  always_comb begin
    busy            = (state_q == READ) || (state_q == DRAIN);
    done            = (state_q == DONE);
    bus.mem_rd_en   = rd_en;
    bus.mem_rd_addr = addr_q;
    bus.out_valid   = ~fifo_empty;
    bus.out_data    = fifo_empty ? '0 : head_data;
    bus.out_addr    = fifo_empty ? '0 : head_addr;
    bus.out_last    = fifo_empty ? 1'b0 : head_last;
    sorted_ok       = sorted_q;
    inversions      = inv_q;
  end

  // read address walk, in-flight tag and order checker
  always_comb begin
    addr_d      = addr_q;
    remain_d    = remain_q;
    pend_d      = rd_en;
    pend_addr_d = addr_q;
    pend_last_d = (remain_q == CNT_W'(1));
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    sorted_d    = sorted_q;
    inv_d       = inv_q;
    if (launch) begin
      addr_d      = base_addr;
      remain_d    = count;
      sorted_d    = 1'b1;
      inv_d       = '0;
      have_prev_d = 1'b0;
    end
    if (rd_en) begin
      addr_d   = addr_q + ADDR_W'(1);
      remain_d = remain_q - CNT_W'(1);
    end
    if (pop) begin
      if (have_prev_q && ($signed(head_data) < $signed(prev_q))) begin
        sorted_d = 1'b0;
        if (inv_q != '1) inv_d = inv_q + CNT_W'(1);
      end
      prev_d      = head_data;
      have_prev_d = 1'b1;
    end
  end

  // datapath registers
  always_ff @(posedge clk1) begin
    if (reset) begin
      halted_q    <= 1'b0;
      addr_q      <= '0;
      remain_q    <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_last_q <= 1'b0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      sorted_q    <= 1'b1;
      inv_q       <= '0;
    end else begin
      halted_q    <= halted_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_last_q <= pend_last_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      sorted_q    <= sorted_d;
      inv_q       <= inv_d;
    end
  end

endmodule
